// File: rtl/i2c_master_arbiter_pkg.sv
// rtl/i2c_master_arbiter_pkg.sv - field widths, FSM encodings and captured-request record for the I2C arbiter
package i2c_master_arbiter_pkg;

    localparam int BUS_W  = 2;
    localparam int DEV_W  = 7;
    localparam int REG_W  = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 24;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    typedef struct packed {
        logic              rw;
        logic [BUS_W-1:0]  bus;
        logic [DEV_W-1:0]  dev;
        logic [REG_W-1:0]  reg_addr;
        logic [DATA_W-1:0] data;
    } xact_t;

endpackage

// File: rtl/i2c_master_arbiter_rr_pick.sv
// rtl/i2c_master_arbiter_rr_pick.sv - combinational round-robin picker (valid + pointer -> one-hot grant)
module i2c_master_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               any_o
);

    // Scan from ptr+1 with wrap so the most recently served requester is looked at last
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any_o && valid_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                grant_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin sharing of one i2c_master engine between several requesters
module i2c_master_arbiter
    import i2c_master_arbiter_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter logic [15:0] LAUNCH_CYCLES  = 16'd1024,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter logic [3:0]  GAP_CYCLES     = 4'd2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ-1:0]    req_rw_i,
    input  logic [2*NUM_REQ-1:0]  req_bus_i,
    input  logic [7*NUM_REQ-1:0]  req_dev_i,
    input  logic [8*NUM_REQ-1:0]  req_reg_i,
    input  logic [8*NUM_REQ-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [7:0]            rsp_data_o,
    output logic                  rsp_err_o,
    input  logic [15:0]           divider_i,
    output logic                  i2c_enable_o,
    output logic                  i2c_rw_o,
    output logic [1:0]            i2c_bus_o,
    output logic [6:0]            i2c_dev_o,
    output logic [7:0]            i2c_reg_o,
    output logic [7:0]            i2c_mosi_o,
    output logic [15:0]           i2c_divider_o,
    input  logic [7:0]            i2c_miso_i,
    input  logic                  i2c_busy_i,
    output logic                  busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [2:0]         state;
    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] owner;
    xact_t              xact;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               err_q;
    logic [DATA_W-1:0]  data_q;
    logic               enable_q;

    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any;
    logic               accept;
    logic [PTR_W-1:0]   pick_idx;
    xact_t              pick_xact;

    i2c_master_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr),
        .grant_o (pick_grant),
        .any_o   (pick_any)
    );

    // A grant is only offered while idle and the engine is not already busy
    assign accept      = (state == ST_IDLE) && !i2c_busy_i && pick_any;
    assign req_ready_o = accept ? pick_grant : '0;

    // Shared counter for launch, run and gap phases; saturates rather than wrapping
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    // Encode the one-hot pick and slice that requester's fields out of the flat buses
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
        pick_xact.rw       = req_rw_i[pick_idx];
        pick_xact.bus      = req_bus_i[BUS_W*pick_idx +: BUS_W];
        pick_xact.dev      = req_dev_i[DEV_W*pick_idx +: DEV_W];
        pick_xact.reg_addr = req_reg_i[REG_W*pick_idx +: REG_W];
        pick_xact.data     = req_data_i[DATA_W*pick_idx +: DATA_W];
    end

    // Transaction sequencer: grant, launch against busy, run, drain on timeout, respond, gap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            ptr      <= PTR_W'(NUM_REQ - 1);
            owner    <= '0;
            xact     <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
            enable_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_LAUNCH;
                        ptr      <= pick_idx;
                        owner    <= pick_grant;
                        xact     <= pick_xact;
                        cnt      <= '0;
                        err_q    <= 1'b0;
                        data_q   <= '0;
                        enable_q <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    if (i2c_busy_i) begin
                        enable_q <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_RUN;
                    end else if (cnt_inc >= CNT_W'(LAUNCH_CYCLES)) begin
                        enable_q <= 1'b0;
                        err_q    <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (!i2c_busy_i) begin
                        data_q <= xact.rw ? i2c_miso_i : '0;
                        state  <= ST_DONE;
                    end else if (cnt_inc >= TIMEOUT_CYCLES) begin
                        err_q <= 1'b1;
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_DRAIN: begin
                    // The engine still owns the bus; wait however long it takes
                    if (!i2c_busy_i) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cnt   <= '0;
                    state <= (GAP_CYCLES == 4'd0) ? ST_IDLE : ST_GAP;
                end
                ST_GAP: begin
                    if (cnt_inc >= CNT_W'(GAP_CYCLES)) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign i2c_enable_o  = enable_q;
    assign i2c_rw_o      = xact.rw;
    assign i2c_bus_o     = xact.bus;
    assign i2c_dev_o     = xact.dev;
    assign i2c_reg_o     = xact.reg_addr;
    assign i2c_mosi_o    = xact.data;
    assign i2c_divider_o = divider_i;

    assign busy_o      = (state != ST_IDLE);
    assign rsp_valid_o = (state == ST_DONE) ? owner : '0;
    assign rsp_data_o  = (state == ST_DONE) ? data_q : '0;
    assign rsp_err_o   = (state == ST_DONE) && err_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - self-checking bench for i2c_master_arbiter with a behavioural engine model
module tb_i2c_master_arbiter;

    localparam int          N      = 4;
    localparam logic [15:0] LAUNCH = 16'd1024;
    localparam logic [23:0] TMO    = 24'd500;
    localparam logic [3:0]  GAP    = 4'd2;

    typedef struct packed {
        logic       rw;
        logic [1:0] bus;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] dat;
    } tb_xact_t;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_valid_i, req_ready_o, req_rw_i, rsp_valid_o;
    logic [2*N-1:0] req_bus_i;
    logic [7*N-1:0] req_dev_i;
    logic [8*N-1:0] req_reg_i, req_data_i;
    logic [7:0]     rsp_data_o;
    logic           rsp_err_o;
    logic [15:0]    divider_i, i2c_divider_o;
    logic           i2c_enable_o, i2c_rw_o;
    logic [1:0]     i2c_bus_o;
    logic [6:0]     i2c_dev_o;
    logic [7:0]     i2c_reg_o, i2c_mosi_o;
    logic [7:0]     i2c_miso_i = 8'h00;
    logic           i2c_busy_i;
    logic           busy_o;

    i2c_master_arbiter #(
        .NUM_REQ(N), .LAUNCH_CYCLES(LAUNCH), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
        .req_bus_i(req_bus_i), .req_dev_i(req_dev_i), .req_reg_i(req_reg_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .divider_i(divider_i),
        .i2c_enable_o(i2c_enable_o), .i2c_rw_o(i2c_rw_o), .i2c_bus_o(i2c_bus_o), .i2c_dev_o(i2c_dev_o),
        .i2c_reg_o(i2c_reg_o), .i2c_mosi_o(i2c_mosi_o), .i2c_divider_o(i2c_divider_o),
        .i2c_miso_i(i2c_miso_i), .i2c_busy_i(i2c_busy_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural engine: busy rises a few cycles after enable, holds eng_len cycles, returns eng_miso
    logic       eng_busy = 1'b0;
    logic       ext_busy = 1'b0;
    int         eng_phase = 0, eng_cnt = 0, eng_len = 200;
    bit         eng_dead = 1'b0, eng_rand_miso = 1'b0;
    logic [7:0] eng_miso = 8'h00;
    assign i2c_busy_i = eng_busy | ext_busy;

    always @(posedge clk_i) begin
        if (rst_i) begin
            eng_phase = 0;
            eng_busy <= 1'b0;
        end else begin
            case (eng_phase)
                0: if (i2c_enable_o && !eng_dead) begin eng_phase = 1; eng_cnt = 1; end
                1: if (eng_cnt == 2) begin
                       eng_miso = eng_rand_miso ? 8'($urandom) : 8'hA5;
                       i2c_miso_i <= eng_miso;
                       eng_busy   <= 1'b1;
                       eng_phase  = 2;
                       eng_cnt    = 1;
                   end else eng_cnt++;
                2: if (eng_cnt >= eng_len) begin eng_busy <= 1'b0; eng_phase = 0; end
                   else eng_cnt++;
                default: eng_phase = 0;
            endcase
        end
    end

    // Bench state: per-requester request FIFOs and the reference arbitration/response model
    tb_xact_t pend [N][8];
    int       head [N];
    int       tail [N];
    int       errors = 0, checks = 0;
    int       cyc = 0, last_served = N - 1;
    int       grant_cyc = 0, rsp_cyc = 0, busy_fall_cyc = 0, en_cycles = 0;
    int       rsp_cnt = 0, issued = 0, cur_owner = 0;
    bit       inflight = 0, gap_armed = 0, prev_en = 0, prev_busy = 0, exp_err = 0;
    tb_xact_t cur;
    int       grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic bit pending_any();
        for (int i = 0; i < N; i++) if (tail[i] != head[i]) return 1'b1;
        return 1'b0;
    endfunction

    // First requester with a pending request, scanning after the one served last
    function automatic int ref_pick();
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last_served + k) % N;
            if (tail[i] != head[i]) return i;
        end
        return -1;
    endfunction

    task automatic push(input int i, input tb_xact_t x);
        pend[i][tail[i] % 8] = x;
        tail[i]++;
        issued++;
    endtask

    function automatic tb_xact_t rand_x();
        tb_xact_t x;
        x.rw = 1'($urandom); x.bus = 2'($urandom); x.dev = 7'($urandom);
        x.rg = 8'($urandom); x.dat = 8'($urandom);
        return x;
    endfunction

    // Idle requesters show garbage fields so held engine inputs are exercised continuously
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            tb_xact_t x;
            x = (tail[i] != head[i]) ? pend[i][head[i] % 8] : rand_x();
            req_valid_i[i]       = (tail[i] != head[i]);
            req_rw_i[i]          = x.rw;
            req_bus_i[2*i +: 2]  = x.bus;
            req_dev_i[7*i +: 7]  = x.dev;
            req_reg_i[8*i +: 8]  = x.rg;
            req_data_i[8*i +: 8] = x.dat;
        end
    endtask

    task automatic step();
        int g;
        g = -1;
        @(negedge clk_i);
        cyc++;
        if (prev_busy && !i2c_busy_i) busy_fall_cyc = cyc;
        prev_busy = i2c_busy_i;
        if (i2c_enable_o && !prev_en && inflight) chk("enable_latency", cyc - grant_cyc, 1);
        prev_en = i2c_enable_o;
        if (inflight && i2c_enable_o) en_cycles++;
        if (req_ready_o != '0) begin
            for (int i = 0; i < N; i++) if (req_ready_o[i]) g = i;
            chk("grant_onehot", $countones(req_ready_o), 1);
            chk("grant_idx", g, ref_pick());
            chk("grant_when_free", 32'(i2c_busy_i | inflight), 0);
            if (gap_armed) chk("gap_to_grant", cyc - rsp_cyc, 32'(GAP) + 1);
            gap_armed = 0;
            cur = pend[g][head[g] % 8];
            cur_owner = g; inflight = 1; grant_cyc = cyc; en_cycles = 0;
            last_served = g;
            grant_log.push_back(g);
        end
        if (rsp_valid_o != '0) begin
            chk("rsp_expected", 32'(inflight), 1);
            chk("rsp_owner", 32'(rsp_valid_o), 32'(1) << cur_owner);
            chk("rsp_err", 32'(rsp_err_o), 32'(exp_err));
            chk("rsp_data", rsp_data_o, (exp_err || !cur.rw) ? 32'h0 : 32'(eng_miso));
            chk("fields_held", {i2c_rw_o, i2c_bus_o, i2c_dev_o, i2c_reg_o, i2c_mosi_o}, 32'(cur));
            if (eng_dead) chk("launch_enable_cycles", en_cycles, 32'(LAUNCH));
            else chk("rsp_after_busy_fall", cyc - busy_fall_cyc, 1);
            inflight = 0; rsp_cnt++; rsp_cyc = cyc;
            gap_armed = pending_any();
        end
        @(posedge clk_i);
        #1;
        if (g >= 0) head[g]++;
        drive();
    endtask

    task automatic run_all(input int maxc);
        int n;
        n = 0;
        while ((pending_any() || inflight || busy_o) && n < maxc) begin
            step();
            n++;
        end
        chk("run_bound", 32'(n < maxc), 1);
        chk("rsp_count", rsp_cnt, issued);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_enable", 32'(i2c_enable_o), 0);
        chk("rst_busy_o", 32'(busy_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        @(posedge clk_i);
        #1;
        chk("rst_rsp_data_err", {rsp_data_o, rsp_err_o}, 0);
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_engine_fields", {i2c_rw_o, i2c_bus_o, i2c_dev_o, i2c_reg_o, i2c_mosi_o}, 0);
        chk("divider_pass", i2c_divider_o, 32'(divider_i));
        rst_i = 1'b0;
        inflight = 0; gap_armed = 0; last_served = N - 1;
        prev_en = 0; prev_busy = 0; issued = rsp_cnt;
    endtask

    initial begin
        int       n;
        int       exp_order [5] = '{0, 1, 2, 3, 0};
        tb_xact_t x;
        rst_i = 1'b1;
        divider_i = 16'($urandom);
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        drive();
        do_reset();

        // Single read from requester 0
        x = '{rw: 1'b1, bus: 2'd1, dev: 7'h50, rg: 8'h10, dat: 8'h00};
        push(0, x); drive();
        grant_log.delete();
        run_all(2000);
        chk("single_grant_idx", (grant_log.size() == 1) ? grant_log[0] : -1, 0);

        // All four at once plus a second request from 0: fairness puts it last
        do_reset();
        for (int i = 0; i < N; i++) push(i, rand_x());
        push(0, rand_x());
        drive();
        grant_log.delete();
        run_all(3000);
        for (int k = 0; k < 5; k++) chk("rr_order", (grant_log.size() > k) ? grant_log[k] : -1, exp_order[k]);

        // Engine never answers: launch errors, second grant follows after the gap
        eng_dead = 1; exp_err = 1;
        x = rand_x(); x.rw = 1'b1;
        push(1, x); push(2, rand_x()); drive();
        run_all(4000);
        eng_dead = 0;

        // Busy outlives the run timeout: error reported only once busy drops
        eng_len = 1200;
        x = rand_x(); x.rw = 1'b1;
        push(3, x); drive();
        run_all(3000);
        eng_len = 200; exp_err = 0;

        // Engine busy from outside while idle: no grant
        ext_busy = 1'b1;
        push(2, rand_x()); drive();
        for (int k = 0; k < 20; k++) begin
            step();
            chk("no_grant_ext_busy", 32'(req_ready_o), 0);
        end
        ext_busy = 1'b0;
        run_all(1000);

        // Register changes after accept must not reach the engine
        x = '{rw: 1'b0, bus: 2'd2, dev: 7'h21, rg: 8'h33, dat: 8'h5C};
        push(3, x); drive();
        step();
        for (int k = 0; k < 10; k++) step();
        chk("reg_held_mid", i2c_reg_o, 32'h33);
        run_all(1000);

        // Reset while running: nothing comes back, then normal service resumes
        x = rand_x(); x.rw = 1'b1;
        push(1, x); drive();
        n = 0;
        while (!i2c_busy_i && n < 100) begin step(); n++; end
        chk("busy_seen", 32'(i2c_busy_i), 1);
        for (int k = 0; k < 10; k++) step();
        do_reset();
        for (int k = 0; k < 20; k++) step();
        push(1, rand_x()); drive();
        run_all(1000);

        // Randomised traffic with random engine timing and read data
        eng_rand_miso = 1;
        for (int r = 0; r < 4; r++) begin
            eng_len = 5 + int'($urandom_range(55));
            for (int i = 0; i < N; i++) begin
                n = int'($urandom_range(3));
                for (int j = 0; j < n; j++) push(i, rand_x());
            end
            drive();
            run_all(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
